insn_encoder: RTL and testbench
===============================

// Module: insn_encoder
// PURPOSE
//  Field-to-word RV32I instruction encoder, the inverse of the decode stage. Accepts format + fields
//  (opcode/rd/rs1/rs2/funct3/funct7/imm) over valid/ready and range-checks the immediate.
//  Packs a 32-bit instruction and tags it with a sequential load address (BASE_ADDR + 4*n).
//  Buffers results in a DEPTH-entry FIFO feeding the imem loader and bench stimulus generator.
// PARAMETERS
//  DWIDTH     32            instruction/immediate width (only 32 supported)
//  AWIDTH     32            address width
//  DEPTH      4             output FIFO entries; power of 2, >=2
//  BASE_ADDR  32'h0100_0000 address of first emitted instruction and after clr_i
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  clr_i      in   1       sync clear: empty FIFO, addr <- BASE_ADDR, err_cnt <- 0
//  in_valid_i in   1       input fields valid
//  in_ready_o out  1       encoder can accept (FIFO not full)
//  fmt_i      in   3       0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
//  opcode_i   in   7       opcode, copied to insn[6:0]
//  rd_i, rs1_i, rs2_i  in  5 each  register IDs
//  funct3_i   in   3       funct3
//  funct7_i   in   7       funct7 (R-type, and I-type shifts)
//  imm_i      in   DWIDTH  sign-extended byte-offset immediate (U: full value, low 12 bits zero)
//  out_valid_o out 1       FIFO head valid
//  out_ready_i in  1       consumer takes head
//  insn_o     out  DWIDTH  encoded instruction at head
//  addr_o     out  AWIDTH  address tag at head
//  err_o      out  1       one-cycle pulse: rejected input
//  err_cnt_o  out  8       saturating count of rejected inputs
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, out_valid_o=0, insn_o=0, addr_o=0, err_o=0, err_cnt_o=0,
//   next addr=BASE_ADDR, in_ready_o=1 after release. Cleared state identical on clr_i (clr_i wins).
//  Accept = in_valid_i & in_ready_o. Encode/check combinational on accept; entry pushed same edge;
//   visible at head next cycle when FIFO was empty (latency 1). in_ready_o = !full (no bypass).
//  Packing: R: f7|rs2|rs1|f3|rd|op. I: imm[11:0]|rs1|f3|rd|op; shift (op=0x13, f3=1/5): f7|imm[4:0].
//   S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op. B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
//   U: imm[31:12]|rd|op. J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op. Unused fields ignored.
//  Errors (input consumed, not pushed, addr not advanced, err_o=1 next cycle, err_cnt_o+1 sat 255):
//   fmt 6/7; I/S imm outside [-2048,2047]; B imm outside [-4096,4094] or odd;
//   J imm outside [-2^20,2^20-2] or odd; U imm[11:0]!=0; I-shift imm outside [0,31].
//  Address: each push stores current addr then addr += 4; wraps mod 2^AWIDTH silently.
//  Pop = out_valid_o & out_ready_i. Simultaneous push+pop when not full: both occur, count unchanged.
//  Full: in_ready_o=0, inputs held by producer. Empty: out_valid_o=0; insn_o/addr_o hold last head.
//  out_valid_o/insn_o/addr_o stable while out_valid_o & !out_ready_i.
//  Reset/clr mid-stream: buffered entries discarded, never emitted.
// TESTING
//  I addi: fmt=1 op=0x13 rd=1 rs1=0 f3=0 imm=5 -> insn 0x00500093, addr 0x0100_0000
//  R then B back-to-back: add x3,x1,x2 -> 0x002081B3 @0x0100_0000; beq x1,x2,+8 -> 0x00208463 @..04
//  U/J: lui x5 imm=0x12345000 -> 0x123452B7; jal x1 imm=2048 -> 0x001000EF
//  Errors: fmt=1 imm=2048 and fmt=3 imm=3 -> 2 err_o pulses, err_cnt_o=2, nothing pushed, addr unchanged
//  Backpressure: out_ready_i=0, push 5 -> in_ready_o=0 after 4, head stable; release -> 4 in order
//  rst low with 3 buffered -> out_valid_o=0 immediately; next push gets addr 0x0100_0000

Source files
------------

// File: rtl/insn_encoder.sv
// RV32I field-to-word encoder: packs and range-checks instruction fields, tags each
// accepted word with a sequential load address and queues it in a small output FIFO.
module insn_encoder #(
    parameter int                 DWIDTH    = 32,
    parameter int                 AWIDTH    = 32,
    parameter int                 DEPTH     = 4,
    parameter logic [AWIDTH-1:0]  BASE_ADDR = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        fmt_i,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [DWIDTH-1:0] imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] addr_o,
    output logic              err_o,
    output logic [7:0]        err_cnt_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem_insn_q [DEPTH];
    logic [DWIDTH-1:0] mem_insn_d [DEPTH];
    logic [AWIDTH-1:0] mem_addr_q [DEPTH];
    logic [AWIDTH-1:0] mem_addr_d [DEPTH];
    logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AWIDTH-1:0] next_addr_q, next_addr_d;
    logic [DWIDTH-1:0] last_insn_q, last_insn_d;
    logic [AWIDTH-1:0] last_addr_q, last_addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [DWIDTH-1:0] insn_enc;
    logic              bad, is_shift, fits12, fits13, fits21;
    logic              full, empty, accept, push, pop;
    logic [PW-1:0]     wr_idx, rd_idx;

    // An immediate fits N signed bits when everything above bit N-2 is a copy of the sign.
    assign fits12   = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits13   = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fits21   = (&imm_i[31:20]) | ~(|imm_i[31:20]);
    assign is_shift = (opcode_i == 7'h13) && ((funct3_i == 3'd1) || (funct3_i == 3'd5));

    always_comb begin
        insn_enc = '0;
        bad      = 1'b0;
        case (fmt_i)
            3'd0: insn_enc = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            3'd1: begin
                if (is_shift) begin
                    insn_enc = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                    bad      = |imm_i[31:5];
                end else begin
                    insn_enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                    bad      = !fits12;
                end
            end
            3'd2: begin
                insn_enc = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                bad      = !fits12;
            end
            3'd3: begin
                insn_enc = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
                bad      = !fits13 || imm_i[0];
            end
            3'd4: begin
                insn_enc = {imm_i[31:12], rd_i, opcode_i};
                bad      = |imm_i[11:0];
            end
            3'd5: begin
                insn_enc = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                bad      = !fits21 || imm_i[0];
            end
            default: bad = 1'b1;
        endcase
    end

    assign wr_idx      = wr_ptr_q[PW-1:0];
    assign rd_idx      = rd_ptr_q[PW-1:0];
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
    assign in_ready_o  = !full;
    assign accept      = in_valid_i && in_ready_o;
    assign push        = accept && !bad;
    assign pop         = out_valid_o && out_ready_i;
    assign out_valid_o = !empty;
    // Once drained, the outputs keep showing the last entry that was popped.
    assign insn_o      = empty ? last_insn_q : mem_insn_q[rd_idx];
    assign addr_o      = empty ? last_addr_q : mem_addr_q[rd_idx];
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;

    always_comb begin
        mem_insn_d  = mem_insn_q;
        mem_addr_d  = mem_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        next_addr_d = next_addr_q;
        last_insn_d = last_insn_q;
        last_addr_d = last_addr_q;
        err_d       = accept && bad;
        err_cnt_d   = err_cnt_q;
        if (accept && bad && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        if (push) begin
            mem_insn_d[wr_idx] = insn_enc;
            mem_addr_d[wr_idx] = next_addr_q;
            wr_ptr_d           = wr_ptr_q + (PW+1)'(1);
            next_addr_d        = next_addr_q + AWIDTH'(4);
        end
        if (pop) begin
            last_insn_d = mem_insn_q[rd_idx];
            last_addr_d = mem_addr_q[rd_idx];
            rd_ptr_d    = rd_ptr_q + (PW+1)'(1);
        end
        if (clr_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            next_addr_d = BASE_ADDR;
            last_insn_d = '0;
            last_addr_d = '0;
            err_d       = 1'b0;
            err_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_insn_q[i] <= '0;
                mem_addr_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            next_addr_q <= BASE_ADDR;
            last_insn_q <= '0;
            last_addr_q <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            mem_insn_q  <= mem_insn_d;
            mem_addr_q  <= mem_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            next_addr_q <= next_addr_d;
            last_insn_q <= last_insn_d;
            last_addr_q <= last_addr_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_insn_encoder.sv
// Directed bench for insn_encoder: encodings, errors, backpressure, reset and clear.
module tb_insn_encoder;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst, clr_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, err_o;
    logic [2:0]  fmt_i, funct3_i;
    logic [6:0]  opcode_i, funct7_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [31:0] imm_i, insn_o, addr_o;
    logic [7:0]  err_cnt_o;
    int          n_vec = 0;
    int          n_miss = 0;

    insn_encoder dut (
        .clk(clk), .rst(rst), .clr_i(clr_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .fmt_i(fmt_i), .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .insn_o(insn_o), .addr_o(addr_o), .err_o(err_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic set_f(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = r1; rs2_i = r2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
    endtask

    task automatic push();
        n_vec++;
        if (in_ready_o !== 1'b1) begin n_miss++; $display("FAIL push_ready got %b want 1", in_ready_o); end
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        set_f(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        n_vec++; if (out_valid_o !== 1'b0) begin n_miss++; $display("FAIL rst_valid got %b want 0", out_valid_o); end
        n_vec++; if (insn_o !== 32'h0) begin n_miss++; $display("FAIL rst_insn got %h want 0", insn_o); end
        n_vec++; if (addr_o !== 32'h0) begin n_miss++; $display("FAIL rst_addr got %h want 0", addr_o); end
        n_vec++; if (err_o !== 1'b0 || err_cnt_o !== 8'd0) begin n_miss++; $display("FAIL rst_err got %b/%0d want 0/0", err_o, err_cnt_o); end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (in_ready_o !== 1'b1) begin n_miss++; $display("FAIL rst_ready got %b want 1", in_ready_o); end
    endtask

    task automatic test_addi();
        set_f(1, 7'h13, 1, 0, 0, 0, 0, 32'd5);
        push();
        n_vec++; if (out_valid_o !== 1'b1) begin n_miss++; $display("FAIL addi_valid got %b want 1", out_valid_o); end
        n_vec++; if (insn_o !== 32'h00500093) begin n_miss++; $display("FAIL addi_insn got %h want 00500093", insn_o); end
        n_vec++; if (addr_o !== BASE) begin n_miss++; $display("FAIL addi_addr got %h want %h", addr_o, BASE); end
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        n_vec++; if (out_valid_o !== 1'b0) begin n_miss++; $display("FAIL addi_pop_valid got %b want 0", out_valid_o); end
        n_vec++; if (insn_o !== 32'h00500093 || addr_o !== BASE) begin n_miss++; $display("FAIL addi_hold got %h@%h want 00500093@%h", insn_o, addr_o, BASE); end
        do_clr();
        n_vec++; if (insn_o !== 32'h0 || addr_o !== 32'h0) begin n_miss++; $display("FAIL clr_outputs got %h@%h want 0@0", insn_o, addr_o); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        out_ready_i = 1'b0;
        set_f(0, 7'h33, 3, 1, 2, 0, 0, 0);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        set_f(3, 7'h63, 0, 1, 2, 0, 0, 32'd8);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        n_vec++; if (insn_o !== 32'h002081B3 || addr_o !== BASE) begin n_miss++; $display("FAIL b2b_add got %h@%h want 002081b3@%h", insn_o, addr_o, BASE); end
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (insn_o !== 32'h00208463 || addr_o !== BASE + 32'd4) begin n_miss++; $display("FAIL b2b_beq got %h@%h want 00208463@%h", insn_o, addr_o, BASE + 32'd4); end
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        n_vec++; if (out_valid_o !== 1'b0) begin n_miss++; $display("FAIL b2b_drain got %b want 0", out_valid_o); end
    endtask

    task automatic test_u_j();
        do_clr();
        out_ready_i = 1'b1;
        set_f(4, 7'h37, 5, 0, 0, 0, 0, 32'h12345000);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (insn_o !== 32'h123452B7 || addr_o !== BASE) begin n_miss++; $display("FAIL lui got %h@%h want 123452b7@%h", insn_o, addr_o, BASE); end
        set_f(5, 7'h6F, 1, 0, 0, 0, 0, 32'd2048);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        n_vec++; if (out_valid_o !== 1'b1 || insn_o !== 32'h001000EF || addr_o !== BASE + 32'd4) begin n_miss++; $display("FAIL jal got %b %h@%h want 1 001000ef@%h", out_valid_o, insn_o, addr_o, BASE + 32'd4); end
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        n_vec++; if (out_valid_o !== 1'b0) begin n_miss++; $display("FAIL uj_drain got %b want 0", out_valid_o); end
    endtask

    task automatic test_misc_formats();
        logic [2:0]  fm [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd1};
        logic [6:0]  op [5] = '{7'h13, 7'h13, 7'h23, 7'h63, 7'h13};
        logic [2:0]  f3 [5] = '{3'd1, 3'd5, 3'd2, 3'd0, 3'd0};
        logic [6:0]  f7 [5] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
        logic [4:0]  rd [5] = '{5'd1, 5'd1, 5'd0, 5'd0, 5'd0};
        logic [4:0]  r1 [5] = '{5'd2, 5'd2, 5'd1, 5'd0, 5'd0};
        logic [4:0]  r2 [5] = '{5'd0, 5'd0, 5'd2, 5'd0, 5'd0};
        logic [31:0] im [5] = '{32'd3, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_F000, 32'hFFFF_F800};
        logic [31:0] ex [5] = '{32'h00311093, 32'h40315093, 32'hFE20AE23, 32'h80000063, 32'h80000013};
        do_clr();
        out_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_f(fm[k], op[k], rd[k], r1[k], r2[k], f3[k], f7[k], im[k]);
            push();
            n_vec++; if (insn_o !== ex[k] || addr_o !== BASE + 32'(4 * k)) begin n_miss++; $display("FAIL fmt_vec%0d got %h@%h want %h@%h", k, insn_o, addr_o, ex[k], BASE + 32'(4 * k)); end
            @(posedge clk); #1;
        end
        out_ready_i = 1'b0;
    endtask

    task automatic test_errors();
        logic [2:0]  fm [8] = '{3'd1, 3'd3, 3'd6, 3'd1, 3'd4, 3'd5, 3'd2, 3'd3};
        logic [6:0]  op [8] = '{7'h13, 7'h63, 7'h13, 7'h13, 7'h37, 7'h6F, 7'h23, 7'h63};
        logic [2:0]  f3 [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd0};
        logic [31:0] im [8] = '{32'd2048, 32'd3, 32'd0, 32'd32, 32'h12345001,
                                32'h0010_0000, 32'hFFFF_F7FF, 32'd4096};
        do_clr();
        out_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_f(fm[k], op[k], 1, 2, 3, f3[k], 0, im[k]);
            push();
            n_vec++; if (err_o !== 1'b1 || out_valid_o !== 1'b0) begin n_miss++; $display("FAIL err_vec%0d got err=%b valid=%b want 1/0", k, err_o, out_valid_o); end
            if (k == 1) begin
                n_vec++; if (err_cnt_o !== 8'd2) begin n_miss++; $display("FAIL err_cnt2 got %0d want 2", err_cnt_o); end
            end
            @(posedge clk); #1;
            n_vec++; if (err_o !== 1'b0) begin n_miss++; $display("FAIL err_pulse%0d got %b want 0", k, err_o); end
        end
        n_vec++; if (err_cnt_o !== 8'd8) begin n_miss++; $display("FAIL err_cnt8 got %0d want 8", err_cnt_o); end
        set_f(1, 7'h13, 1, 0, 0, 0, 0, 32'd5);
        push();
        n_vec++; if (insn_o !== 32'h00500093 || addr_o !== BASE) begin n_miss++; $display("FAIL err_addr_kept got %h@%h want 00500093@%h", insn_o, addr_o, BASE); end
        set_f(7, 0, 0, 0, 0, 0, 0, 0);
        in_valid_i = 1'b1;
        repeat (260) @(posedge clk);
        #1; in_valid_i = 1'b0;
        n_vec++; if (err_cnt_o !== 8'd255) begin n_miss++; $display("FAIL err_sat got %0d want 255", err_cnt_o); end
        do_clr();
        n_vec++; if (err_cnt_o !== 8'd0) begin n_miss++; $display("FAIL clr_errcnt got %0d want 0", err_cnt_o); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rec_i [5];
        logic [31:0] rec_a [5];
        logic [31:0] exp_i;
        int got = 0;
        logic acc;
        do_clr();
        out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_f(1, 7'h13, 5'(k + 1), 0, 0, 0, 0, 32'(k));
            push();
        end
        n_vec++; if (in_ready_o !== 1'b0) begin n_miss++; $display("FAIL bp_full got %b want 0", in_ready_o); end
        set_f(1, 7'h13, 5'd5, 0, 0, 0, 0, 32'd4);
        in_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (in_ready_o !== 1'b0 || insn_o !== 32'h00000093 || addr_o !== BASE) begin n_miss++; $display("FAIL bp_stable got rdy=%b %h@%h want 0 00000093@%h", in_ready_o, insn_o, addr_o, BASE); end
        out_ready_i = 1'b1;
        for (int c = 0; c < 20 && got < 5; c++) begin
            acc = in_valid_i & in_ready_o;
            if (out_valid_o) begin rec_i[got] = insn_o; rec_a[got] = addr_o; got++; end
            @(posedge clk); #1;
            if (acc) in_valid_i = 1'b0;
        end
        out_ready_i = 1'b0;
        in_valid_i = 1'b0;
        n_vec++; if (got != 5) begin n_miss++; $display("FAIL bp_count got %0d want 5", got); end
        for (int k = 0; k < got; k++) begin
            exp_i = (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13;
            n_vec++; if (rec_i[k] !== exp_i || rec_a[k] !== BASE + 32'(4 * k)) begin n_miss++; $display("FAIL bp_order%0d got %h@%h want %h@%h", k, rec_i[k], rec_a[k], exp_i, BASE + 32'(4 * k)); end
        end
    endtask

    task automatic test_reset_mid();
        do_clr();
        out_ready_i = 1'b0;
        set_f(1, 7'h13, 2, 0, 0, 0, 0, 32'd1);
        repeat (3) push();
        n_vec++; if (out_valid_o !== 1'b1) begin n_miss++; $display("FAIL mid_prefill got %b want 1", out_valid_o); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin n_miss++; $display("FAIL mid_rst got valid=%b rdy=%b want 0/1", out_valid_o, in_ready_o); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        set_f(1, 7'h13, 1, 0, 0, 0, 0, 32'd7);
        push();
        n_vec++; if (insn_o !== 32'h00700093 || addr_o !== BASE) begin n_miss++; $display("FAIL mid_after got %h@%h want 00700093@%h", insn_o, addr_o, BASE); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_u_j();
        test_misc_formats();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
